// File: rtl/mpmc11_pkg.sv
// rtl/mpmc11_pkg.sv - shared types and constants for the mpmc11 read burst controller
package mpmc11_pkg;

  typedef enum logic [2:0] {
    RDC_IDLE      = 3'd0,
    RDC_PRESET    = 3'd1,
    RDC_ISSUE     = 3'd2,
    RDC_READ_DATA = 3'd3,
    RDC_DONE      = 3'd4
  } mpmc11_rdctl_state_t;

  localparam int          MPMC11_LINE_OFFS_BITS = 5;
  localparam logic [31:0] MPMC11_ADDR_MASK      = 32'h3FFF_FFFF;

  // Clears the byte-within-line offset so commands always start on a line boundary.
  function automatic logic [31:0] mpmc11_line_align(input logic [31:0] a);
    return {a[31:MPMC11_LINE_OFFS_BITS], {MPMC11_LINE_OFFS_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mpmc11_rdctl_watchdog.sv
// rtl/mpmc11_rdctl_watchdog.sv - idle-cycle counter with expiry flag (used with MPMC11_RDCTRL_TIMEOUT_EN)
module mpmc11_rdctl_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned     W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  // Counter sits at zero outside the run window, so entry into ISSUE starts fresh.
  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run & ~i_clr & (r_cnt == LAST);

endmodule

// File: rtl/mpmc11_rd_burst_ctrl.sv
// rtl/mpmc11_rd_burst_ctrl.sv - cache-line read burst sequencer; optional timeout abort via MPMC11_RDCTRL_TIMEOUT_EN
module mpmc11_rd_burst_ctrl
  import mpmc11_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic                req_ack,
  input  logic [31:0]         req_addr,
  input  logic [7:0]          req_burst_len,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [31:0]         cmd_addr,
  output logic [7:0]          cmd_len,
  input  logic                rd_valid,
  output mpmc11_rdctl_state_t state,
  output logic [7:0]          burst_len,
  output logic [7:0]          burst_cnt,
  output logic [31:0]         addr_base,
  output logic                cache_we,
  output logic                busy,
  output logic                done,
  output logic                err
);

  mpmc11_rdctl_state_t r_state, w_state_nxt;
  logic [31:0] r_addr_base, r_cmd_addr;
  logic [7:0]  r_burst_len, r_burst_cnt, r_cmd_len;
  logic        w_accept, w_hshake, w_beat, w_last, w_expired;

  // Ack is suppressed in the reset cycle so an accepted request is never lost.
  assign w_accept = (r_state == RDC_IDLE) & req & ~rst;
  assign w_hshake = (r_state == RDC_ISSUE) & cmd_ready;
  assign w_beat   = (r_state == RDC_READ_DATA) & rd_valid;
  assign w_last   = w_beat & (r_burst_cnt == r_burst_len);

`ifdef MPMC11_RDCTRL_TIMEOUT_EN
  logic r_err;

  mpmc11_rdctl_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_run     ((r_state == RDC_ISSUE) || (r_state == RDC_READ_DATA)),
    .i_clr     (w_hshake | w_beat),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_expired) begin
      r_err <= 1'b1;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic [9:0] w_timeout_unused;

  assign w_timeout_unused = 10'(TIMEOUT_CYC);
  assign w_expired        = 1'b0;
  assign err              = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RDC_IDLE:      if (w_accept) w_state_nxt = RDC_PRESET;
      RDC_PRESET:    w_state_nxt = RDC_ISSUE;
      RDC_ISSUE:     if (w_expired) w_state_nxt = RDC_DONE;
                     else if (cmd_ready) w_state_nxt = RDC_READ_DATA;
      RDC_READ_DATA: if (w_last || w_expired) w_state_nxt = RDC_DONE;
      RDC_DONE:      w_state_nxt = RDC_IDLE;
      default:       w_state_nxt = RDC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RDC_IDLE;
      r_addr_base <= '0;
      r_burst_len <= '0;
      r_burst_cnt <= '0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr_base <= req_addr & MPMC11_ADDR_MASK;
        r_burst_len <= req_burst_len;
      end
      if (r_state == RDC_PRESET) begin
        r_burst_cnt <= '0;
        r_cmd_addr  <= mpmc11_line_align(r_addr_base);
        r_cmd_len   <= r_burst_len;
      end
      // Count stops at equality, so len=255 yields 256 beats without wrapping.
      if (w_beat && !w_last) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
    end
  end

  assign req_ack   = w_accept;
  assign cmd_valid = (r_state == RDC_ISSUE);
  assign cmd_addr  = r_cmd_addr;
  assign cmd_len   = r_cmd_len;
  assign state     = r_state;
  assign burst_len = r_burst_len;
  assign burst_cnt = r_burst_cnt;
  assign addr_base = r_addr_base;
  assign cache_we  = w_beat;
  assign busy      = (r_state != RDC_IDLE);
  assign done      = (r_state == RDC_DONE);

endmodule

// File: tb/tb_mpmc11_rd_burst_ctrl.sv
// tb/tb_mpmc11_rd_burst_ctrl.sv - directed scoreboard bench for mpmc11_rd_burst_ctrl
module tb_mpmc11_rd_burst_ctrl;
  import mpmc11_pkg::*;

  logic                clk = 1'b0;
  logic                rst, req, cmd_ready, rd_valid;
  logic [31:0]         req_addr;
  logic [7:0]          req_burst_len;
  logic                req_ack, cmd_valid, cache_we, busy, done, err;
  logic [31:0]         cmd_addr, addr_base;
  logic [7:0]          cmd_len, burst_len, burst_cnt;
  mpmc11_rdctl_state_t state;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt[$];
  bit exp_we;

  always #5 clk = ~clk;

  mpmc11_rd_burst_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_ack       (req_ack),
    .req_addr      (req_addr),
    .req_burst_len (req_burst_len),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .rd_valid      (rd_valid),
    .state         (state),
    .burst_len     (burst_len),
    .burst_cnt     (burst_cnt),
    .addr_base     (addr_base),
    .cache_we      (cache_we),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle: cache_we must match the bench's expectation; each strobe pops the expected beat index.
  task automatic mon();
    chk("cache_we", 32'(cache_we), 32'(exp_we));
    if (cache_we && exp_we) begin
      if (exp_cnt.size() == 0) chk("beat_overrun", 32'(burst_cnt), 32'hFFFF_FFFF);
      else chk("beat_cnt", 32'(burst_cnt), 32'(exp_cnt.pop_front()));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_state", 32'(state), 32'(RDC_IDLE));
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_len", 32'(cmd_len), 0);
    chk("rst_burst_len", 32'(burst_len), 0);
    chk("rst_burst_cnt", 32'(burst_cnt), 0);
    chk("rst_addr_base", addr_base, 0);
    chk("rst_cache_we", 32'(cache_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [7:0] len, input int bp,
                         input bit gaps, input int extra, input int abort_at);
    int got, budget;
    logic [31:0] exp_base, exp_cmd;
    exp_base = addr & 32'h3FFF_FFFF;
    exp_cmd  = {exp_base[31:5], 5'h00};
    for (int i = 0; i <= int'(len); i++) exp_cnt.push_back(i);
    exp_we = 1'b0;
    req = 1'b1; req_addr = addr; req_burst_len = len;
    #1;
    chk("req_ack", 32'(req_ack), 1);
    tick();
    chk("preset_state", 32'(state), 32'(RDC_PRESET));
    chk("addr_base", addr_base, exp_base);
    chk("burst_len", 32'(burst_len), 32'(len));
    chk("busy", 32'(busy), 1);
    chk("ack_busy", 32'(req_ack), 0);
    tick();
    chk("cmd_valid", 32'(cmd_valid), 1);
    chk("cmd_addr", cmd_addr, exp_cmd);
    chk("cmd_len", 32'(cmd_len), 32'(len));
    chk("cnt_preset", 32'(burst_cnt), 0);
    for (int i = 0; i < bp; i++) begin
      cmd_ready = 1'b0; rd_valid = 1'b1;
      tick();
      chk("bp_cmd_valid", 32'(cmd_valid), 1);
      chk("bp_cmd_addr", cmd_addr, exp_cmd);
      chk("bp_state", 32'(state), 32'(RDC_ISSUE));
    end
    rd_valid = 1'b0; cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0; req = 1'b0;
    chk("rd_state", 32'(state), 32'(RDC_READ_DATA));
    chk("cmd_drop", 32'(cmd_valid), 0);
    got = 0; budget = 0;
    while (got <= int'(len) && budget < 3000) begin
      if (abort_at >= 0 && got == abort_at) break;
      rd_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_we = rd_valid;
      tick();
      if (rd_valid) got++;
      budget++;
    end
    exp_we = 1'b0;
    if (abort_at >= 0) begin
      rst = 1'b1; rd_valid = 1'b0;
      tick();
      chk_reset();
      rst = 1'b0;
      exp_cnt.delete();
      rd_valid = 1'b1;
      tick();
      tick();
      rd_valid = 1'b0;
      return;
    end
    chk("beats_issued", 32'(got), 32'(len) + 1);
    chk("done_state", 32'(state), 32'(RDC_DONE));
    chk("done_pulse", 32'(done), 1);
    chk("done_cnt", 32'(burst_cnt), 32'(len));
    rd_valid = (extra > 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_state", 32'(state), 32'(RDC_IDLE));
    for (int i = 1; i < extra; i++) tick();
    rd_valid = 1'b0;
    chk("beats_left", 32'(exp_cnt.size()), 0);
    chk("final_cnt", 32'(burst_cnt), 32'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stalled expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; req = 1'b0; cmd_ready = 1'b0; rd_valid = 1'b0;
    req_addr = '0; req_burst_len = '0; exp_we = 1'b0;
    @(posedge clk); #1;
    tick();
    chk_reset();
    rst = 1'b0;
    tick();

    do_load(32'h1234_5678, 8'd3,   0, 1'b0, 0, -1);
    do_load(32'hC000_0047, 8'd1,   5, 1'b0, 2, -1);
    do_load(32'hABCD_EF1F, 8'd0,   1, 1'b1, 1, -1);
    do_load(32'h0000_1000, 8'd255, 0, 1'b1, 0, -1);
    do_load(32'h5555_5555, 8'd3,   0, 1'b0, 0, 2);
    do_load(32'h0F0F_0F20, 8'd7,   2, 1'b1, 0, -1);

`ifdef MPMC11_RDCTRL_TIMEOUT_EN
    req = 1'b1; req_addr = 32'h0000_2000; req_burst_len = 8'd3;
    tick();
    req = 1'b0;
    tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_done", 32'(done), 0);
      tick();
    end
    chk("to_done", 32'(done), 1);
    chk("to_err", 32'(err), 1);
    tick();
    chk("to_err_sticky", 32'(err), 1);
    req = 1'b1;
    #1;
    chk("to_ack", 32'(req_ack), 1);
    tick();
    req = 1'b0;
    chk("to_err_clear", 32'(err), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mpmc11_rd_burst_ctrl.md
Name: mpmc11_rd_burst_ctrl

Overview:
- Sequences one cache-line load from memory.
- Accepts a line-load request, issues a single read command to the memory port and counts the returned data beats.
- Drives state, burst_len, burst_cnt and addr_base to the cache write-address generator, plus a cache write strobe.
- Sits between the port arbiter (upstream) and the memory read interface / cache load path (downstream).

Parameters:
- TIMEOUT_CYC, 1023, idle cycles tolerated in ISSUE/READ_DATA before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  line-load request; held by requester until req_ack
- req_ack  out  1  one-cycle pulse; request accepted
- req_addr  in  32  byte address of line
- req_burst_len  in  8  beats minus one (N means N+1 beats)
- cmd_valid  out  1  read command valid
- cmd_ready  in  1  memory accepts command
- cmd_addr  out  32  line-aligned command address
- cmd_len  out  8  latched burst length
- rd_valid  in  1  memory read-data beat valid
- state  out  mpmc11_rdctl_state_t  current state
- burst_len  out  8  latched req_burst_len
- burst_cnt  out  8  beats accepted so far in this line
- addr_base  out  32  latched request address
- cache_we  out  1  cache write strobe for the current beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at line completion
- err  out  1  timeout abort flag

Behaviour:
- Reset: state=IDLE. All outputs 0: req_ack, cmd_valid, cmd_addr, cmd_len, burst_len, burst_cnt, addr_base, cache_we, done, err.
- Reset mid-operation: returns to IDLE on that edge and drops cmd_valid. In-flight beats are then ignored.
- IDLE:
  - If req=1: latch addr_base={2'b00,req_addr[29:0]} and burst_len=req_burst_len; pulse req_ack; go to PRESET.
  - req must not be re-sampled until back in IDLE. No ack while busy.
- PRESET: one cycle. burst_cnt<=0, cmd_addr<={addr_base[31:5],5'h0}, cmd_len<=burst_len. Go to ISSUE.
- ISSUE:
  - cmd_valid=1, held stable until cmd_ready.
  - On cycle with cmd_valid&cmd_ready: go to READ_DATA; cmd_valid deasserts next cycle.
  - rd_valid seen in ISSUE is ignored (stray).
- READ_DATA:
  - cache_we = rd_valid & (state==READ_DATA), combinational, same cycle as the beat.
  - rd_valid & burst_cnt!=burst_len: burst_cnt+1.
  - rd_valid & burst_cnt==burst_len: burst_cnt holds; go to DONE.
  - Beats are counted modulo 8 bits. burst_len=255 gives 256 beats with no wrap, because the count stops at equality.
- DONE: done=1 for one cycle, then IDLE. rd_valid in DONE or IDLE is ignored (cache_we=0).
- Latency:
  - req to cmd_valid: 2 cycles (ack edge, then PRESET).
  - Last beat to done: 1 cycle.
  - done to next req_ack: minimum 1 cycle.
- burst_len=0: single beat; DONE follows the first rd_valid.
- Back-to-back: req held high through DONE is acked in the first IDLE cycle.

Optional Feature:
- Macro: MPMC11_RDCTRL_TIMEOUT_EN.
- With macro:
  - A 10-bit (clog2 TIMEOUT_CYC+1) idle counter runs in ISSUE and READ_DATA.
  - It clears on entry to ISSUE, on the command handshake and on each accepted beat.
  - On reaching TIMEOUT_CYC: set err (sticky), drop cmd_valid and go to DONE, where done pulses.
  - err clears on the next req_ack.
- Without macro: no counter; err tied 0; the controller waits indefinitely.

Decomposition:
- mpmc11_pkg gains:
  - typedef enum mpmc11_rdctl_state_t {RDC_IDLE, RDC_PRESET, RDC_ISSUE, RDC_READ_DATA, RDC_DONE}.
  - localparam MPMC11_LINE_OFFS_BITS=5.
  - localparam MPMC11_ADDR_MASK=32'h3FFFFFFF.
- One sub-module, mpmc11_rdctl_watchdog (idle counter plus expiry flag), instantiated only under the macro.
- State machine and beat counter stay in the top module.

Test Plan:
- Basic load: req_addr=0x1234_5678, len=3, cmd_ready=1, 4 beats on consecutive cycles -> cmd_addr=0x1234_5660, cmd_len=3, cache_we high for 4 cycles, burst_cnt 0,1,2,3, done 1 cycle after the 4th beat.
- Backpressure: cmd_ready low 5 cycles -> cmd_valid held and stable with cmd_addr unchanged; READ_DATA entered the cycle after cmd_ready=1.
- Extra and stray data: rd_valid in ISSUE and 2 extra beats after the last beat -> cache_we=0 for those beats, burst_cnt never exceeds len.
- Gapped beats, len=0 and len=255:
  - len=0 -> single cache_we, then done.
  - len=255 with random rd_valid gaps -> exactly 256 cache_we, burst_cnt ends at 255.
- Reset mid-burst: rst after 2 of 4 beats -> IDLE next cycle, all outputs 0; remaining beats give cache_we=0; a new req is accepted normally.
- Timeout (macro on, TIMEOUT_CYC=16): no beats after the command handshake -> err=1 and done pulse 16 cycles after the handshake; err clears on the next req_ack.
